cdff_pipe: RTL

- Parametrised successor to the plain CDFF data register: a DEPTH-stage elastic pipeline register with a valid/ready handshake.
- Each stage is a two-entry skid slice, so IN_READY is a registered signal and there is no combinational ready path through the chain.
- Used between AdderNet datapath blocks (adder tree, accumulators, output writers) where a plain CDFF cannot stall or absorb backpressure.
- Full throughput of one word per cycle; latency is DEPTH cycles when unstalled.

---
 rtl/cdff_pkg.sv | 15 +
 rtl/cdff_skid_slice.sv | 86 ++++++++
 rtl/cdff_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/cdff_pkg.sv
// Shared types and helpers for the cdff_pipe elastic pipeline register
// and its skid slices.
package cdff_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/cdff_skid_slice.sv
// Two-entry skid slice: main register feeds the output, skid register
// absorbs one extra word so that S_IN_READY can be a flop.
module cdff_skid_slice
    import cdff_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             S_IN_VALID,
    output logic             S_IN_READY,
    input  logic [WIDTH-1:0] S_IN_DATA,
    output logic             S_OUT_VALID,
    input  logic             S_OUT_READY,
    output logic [WIDTH-1:0] S_OUT_DATA
);

    slice_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        in_fire  = S_IN_VALID & in_ready_q;
        out_fire = out_valid_q & S_OUT_READY;
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = S_IN_DATA;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = S_IN_DATA;
                end else if (in_fire) begin
                    skid_d  = S_IN_DATA;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops held words but leaves the data registers untouched.
        if (FLUSH) begin
            state_d = EMPTY;
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign S_IN_READY  = in_ready_q;
    assign S_OUT_VALID = out_valid_q;
    assign S_OUT_DATA  = main_q;

endmodule

// File: rtl/cdff_pipe.sv
// DEPTH-stage elastic pipeline register built from cascaded skid slices.
// Define CDFF_PIPE_OCC_EN to add the OCC occupancy counter output.
module cdff_pipe
    import cdff_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA
`ifdef CDFF_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] OCC
`endif
);

    if (DEPTH < 1) begin : g_depth_check
        $error("cdff_pipe: DEPTH must be >= 1");
    end

    // Link k sits between slice k-1 and slice k; links 0 and DEPTH are the ports.
    logic [DEPTH:0]            vld;
    logic [DEPTH:0]            rdy;
    logic [DEPTH:0][WIDTH-1:0] dat;

    assign vld[0]     = IN_VALID;
    assign dat[0]     = IN_DATA;
    assign IN_READY   = rdy[0];
    assign OUT_VALID  = vld[DEPTH];
    assign OUT_DATA   = dat[DEPTH];
    assign rdy[DEPTH] = OUT_READY;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        cdff_skid_slice #(
            .WIDTH(WIDTH)
        ) u_slice (
            .CLK        (CLK),
            .RST        (RST),
            .FLUSH      (FLUSH),
            .S_IN_VALID (vld[k]),
            .S_IN_READY (rdy[k]),
            .S_IN_DATA  (dat[k]),
            .S_OUT_VALID(vld[k+1]),
            .S_OUT_READY(rdy[k+1]),
            .S_OUT_DATA (dat[k+1])
        );
    end

`ifdef CDFF_PIPE_OCC_EN
    localparam int OW = occ_width(DEPTH);

    logic [OW-1:0] occ_q, occ_d;
    logic [OW-1:0] occ_sum;

    always_comb begin
        if (FLUSH) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OW'(IN_VALID & IN_READY) - OW'(OUT_VALID & OUT_READY);
        end
        // A slice holds (out_valid + !in_ready) words: 0, 1 or 2.
        occ_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_sum = occ_sum + OW'(vld[k+1]) + OW'(!rdy[k]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCC = occ_q;

    a_occ_matches_slices: assert property (@(posedge CLK) disable iff (RST) occ_q == occ_sum);
`endif

endmodule
